// File: rtl/sram_banked_pkg.sv
// Shared types and helpers for the banked 1W1R SRAM wrapper.
// Holds the init/run state enum, address-width helpers and the lane-merge function.
package sram_banked_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Widest entry the lane-merge helper accepts; callers cast in and out.
  localparam int MAX_W = 1024;
  typedef logic [MAX_W-1:0] wide_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int bank_w(input int depth, input int macro_depth);
    return addr_w(depth / macro_depth);
  endfunction

  // Take forwarded bits where bit_mask is set, stored bits elsewhere.
  function automatic wide_t lane_merge(input wide_t data, input wide_t fwd, input wide_t bit_mask);
    return (fwd & bit_mask) | (data & ~bit_mask);
  endfunction

endpackage

// File: rtl/sram_1w1r_banked_ext_if.sv
// Write port, read port and init status of the banked 1W1R SRAM.
// The master drives commands; the slave (the memory) returns read data and init_done.
interface sram_1w1r_banked_ext_if #(
  parameter int DEPTH     = 128,
  parameter int WIDTH     = 64,
  parameter int MASK_BITS = 4
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]        W0_addr;
  logic [WIDTH-1:0]     W0_data;
  logic                 W0_en;
  logic [MASK_BITS-1:0] W0_mask;
  logic [AW-1:0]        R0_addr;
  logic                 R0_en;
  logic [WIDTH-1:0]     R0_data;
  logic                 R0_valid;
  logic                 init_done;

  modport master (
    output W0_addr, W0_data, W0_en, W0_mask, R0_addr, R0_en,
    input  R0_data, R0_valid, init_done
  );

  modport slave (
    input  W0_addr, W0_data, W0_en, W0_mask, R0_addr, R0_en,
    output R0_data, R0_valid, init_done
  );

endinterface

// File: rtl/sram_1w1r_macro_model.sv
// Behavioural 1W1R SRAM macro: active-low selects, per-lane write mask, registered read.
// Lanes written to the address being read in the same cycle return undefined data.
module sram_1w1r_macro_model #(
  parameter  int DEPTH     = 64,
  parameter  int WIDTH     = 64,
  parameter  int MASK_BITS = 4,
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW        = WIDTH / MASK_BITS
) (
  input  logic                 clk_i,
  input  logic                 csb0_i,
  input  logic [AW-1:0]        addr0_i,
  input  logic [WIDTH-1:0]     din0_i,
  input  logic [MASK_BITS-1:0] wmask0_i,
  input  logic                 csb1_i,
  input  logic [AW-1:0]        addr1_i,
  output logic [WIDTH-1:0]     dout1_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q;

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < MASK_BITS; l++) begin
      if (!csb0_i && wmask0_i[l]) begin
        mem_q[addr0_i][l*LW +: LW] <= din0_i[l*LW +: LW];
      end
      if (!csb1_i) begin
        if (!csb0_i && wmask0_i[l] && (addr0_i == addr1_i)) begin
          dout_q[l*LW +: LW] <= 'x;
        end else begin
          dout_q[l*LW +: LW] <= mem_q[addr1_i][l*LW +: LW];
        end
      end
    end
  end

  assign dout1_o = dout_q;

endmodule

// File: rtl/sram_1w1r_banked_ext.sv
// Depth-tiled 1W1R SRAM: zero-clears after reset, forwards masked same-address writes, holds last read.
// Read latency 1 cycle, or 2 when SRAM_OUT_REG_EN is defined; no backpressure, one read per cycle.
module sram_1w1r_banked_ext
  import sram_banked_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int WIDTH       = 64,
  parameter int MASK_BITS   = 4,
  parameter int MACRO_DEPTH = 64
) (
  input logic                    clock,
  input logic                    reset,
  sram_1w1r_banked_ext_if.slave  mem
);

  localparam int ROW_W = addr_w(MACRO_DEPTH);
  localparam int NBANK = DEPTH / MACRO_DEPTH;
  localparam int BW    = bank_w(DEPTH, MACRO_DEPTH);
  localparam int LW    = WIDTH / MASK_BITS;

  state_e               state_q, state_d;
  logic [ROW_W-1:0]     cnt_q, cnt_d;
  logic [NBANK-1:0]     csb0, csb1;
  logic [ROW_W-1:0]     addr0, addr1;
  logic [WIDTH-1:0]     din0;
  logic [MASK_BITS-1:0] wmask0;
  logic [WIDTH-1:0]     dout1 [NBANK];
  logic [BW-1:0]        wr_bank, rd_bank;
  logic                 rd_go, col, init_done;

  logic                 rd_vld_q, col_q;
  logic [BW-1:0]        rd_bank_q;
  logic [WIDTH-1:0]     fwd_dat_q;
  logic [MASK_BITS-1:0] fwd_mask_q;
  logic [WIDTH-1:0]     hold_q;
  logic [WIDTH-1:0]     bit_mask, rd_raw, rd_merged, res_dat;
  logic                 res_vld;

  assign wr_bank = BW'(mem.W0_addr >> ROW_W);
  assign rd_bank = BW'(mem.R0_addr >> ROW_W);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + ROW_W'(1);
      if (cnt_q == ROW_W'(MACRO_DEPTH - 1)) begin
        state_d = RUN;
      end
    end
  end

  // INIT writes zeros to row cnt of every bank at once; RUN selects only the addressed bank.
  always_comb begin
    csb0      = '1;
    csb1      = '1;
    addr0     = cnt_q;
    addr1     = '0;
    din0      = '0;
    wmask0    = '1;
    rd_go     = 1'b0;
    col       = 1'b0;
    init_done = 1'b0;
    if (state_q == RUN) begin
      init_done = 1'b1;
      addr0     = ROW_W'(mem.W0_addr);
      addr1     = ROW_W'(mem.R0_addr);
      din0      = mem.W0_data;
      wmask0    = mem.W0_mask;
      rd_go     = mem.R0_en;
      col       = mem.W0_en & mem.R0_en & (mem.W0_addr == mem.R0_addr);
      for (int b = 0; b < NBANK; b++) begin
        if (mem.W0_en && (wr_bank == BW'(b))) csb0[b] = 1'b0;
        if (mem.R0_en && (rd_bank == BW'(b))) csb1[b] = 1'b0;
      end
    end else begin
      csb0 = '0;
    end
  end

  for (genvar b = 0; b < NBANK; b++) begin : g_bank
    sram_1w1r_macro_model #(
      .DEPTH     (MACRO_DEPTH),
      .WIDTH     (WIDTH),
      .MASK_BITS (MASK_BITS)
    ) u_macro (
      .clk_i    (clock),
      .csb0_i   (csb0[b]),
      .addr0_i  (addr0),
      .din0_i   (din0),
      .wmask0_i (wmask0),
      .csb1_i   (csb1[b]),
      .addr1_i  (addr1),
      .dout1_o  (dout1[b])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_vld_q   <= 1'b0;
      rd_bank_q  <= '0;
      col_q      <= 1'b0;
      fwd_dat_q  <= '0;
      fwd_mask_q <= '0;
    end else begin
      rd_vld_q <= rd_go;
      if (rd_go) begin
        rd_bank_q <= rd_bank;
        col_q     <= col;
      end
      if (col) begin
        fwd_dat_q  <= mem.W0_data;
        fwd_mask_q <= mem.W0_mask;
      end
    end
  end

  for (genvar l = 0; l < MASK_BITS; l++) begin : g_lane
    assign bit_mask[l*LW +: LW] = {LW{col_q & fwd_mask_q[l]}};
  end

  assign rd_raw    = dout1[rd_bank_q];
  assign rd_merged = WIDTH'(lane_merge(wide_t'(rd_raw), wide_t'(fwd_dat_q), wide_t'(bit_mask)));

`ifdef SRAM_OUT_REG_EN
  logic             out_vld_q;
  logic [WIDTH-1:0] out_dat_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      out_vld_q <= rd_vld_q;
      if (rd_vld_q) out_dat_q <= rd_merged;
    end
  end

  assign res_vld = out_vld_q;
  assign res_dat = out_dat_q;
`else
  assign res_vld = rd_vld_q;
  assign res_dat = rd_merged;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_q <= '0;
    end else if (res_vld) begin
      hold_q <= res_dat;
    end
  end

  assign mem.R0_valid  = res_vld;
  assign mem.R0_data   = res_vld ? res_dat : hold_q;
  assign mem.init_done = init_done;

endmodule
